// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - SAR ADC sequencer: CDAC reset, sample window, MSB-first binary search
// Drives the CDAC code from comparator decisions and pulses eoc with the final code.
module sar_adc_ctrl #(
  parameter int SIZE = 12
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            soc_i,
  input  logic [3:0]      swidth_i,
  input  logic            cmp_i,
  output logic            sample_n_o,
  output logic            dac_rst_o,
  output logic [SIZE-1:0] data_o,
  output logic            eoc_o
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      scnt_q, scnt_d;
  logic [IW-1:0]   bit_q, bit_d;
  logic            sample_n_q, sample_n_d;
  logic            dac_rst_q, dac_rst_d;
  logic [SIZE-1:0] data_q, data_d;
  logic            eoc_q, eoc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      scnt_q     <= '0;
      bit_q      <= '0;
      sample_n_q <= 1'b1;
      dac_rst_q  <= 1'b1;
      data_q     <= '0;
      eoc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bit_q      <= bit_d;
      sample_n_q <= sample_n_d;
      dac_rst_q  <= dac_rst_d;
      data_q     <= data_d;
      eoc_q      <= eoc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (soc_i) state_d = SAMPLE;
        SAMPLE:  if (scnt_q <= 4'd1) state_d = CONV;
        CONV:    if (bit_q == '0) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    scnt_d     = scnt_q;
    bit_d      = bit_q;
    sample_n_d = sample_n_q;
    dac_rst_d  = dac_rst_q;
    data_d     = data_q;
    eoc_d      = 1'b0;
    if (!en_i) begin
      // Abort discards any partial code so a stale trial is never mistaken for a result.
      sample_n_d = 1'b1;
      dac_rst_d  = 1'b1;
      data_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          sample_n_d = 1'b1;
          dac_rst_d  = 1'b1;
          if (soc_i) begin
            sample_n_d = 1'b0;
            dac_rst_d  = 1'b0;
            data_d     = '0;
            scnt_d     = (swidth_i == 4'd0) ? 4'd1 : swidth_i;
          end
        end
        SAMPLE: begin
          scnt_d = scnt_q - 4'd1;
          if (scnt_q <= 4'd1) begin
            sample_n_d = 1'b1;
            data_d     = {1'b1, {(SIZE-1){1'b0}}};
            bit_d      = IW'(SIZE - 1);
          end
        end
        CONV: begin
          data_d[bit_q] = cmp_i;
          if (bit_q != '0) begin
            data_d[bit_q - 1'b1] = 1'b1;
            bit_d                = bit_q - 1'b1;
          end else begin
            eoc_d = 1'b1;
          end
        end
        default: begin
          dac_rst_d = 1'b1;
        end
      endcase
    end
  end

  assign sample_n_o = sample_n_q;
  assign dac_rst_o  = dac_rst_q;
  assign data_o     = data_q;
  assign eoc_o      = eoc_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - scoreboard bench for sar_adc_ctrl
// Expected codes and eoc cycles are queued at soc; a negedge monitor pops them.
module tb_sar_adc_ctrl;
  localparam int SIZE = 12;
  localparam logic [SIZE-1:0] ALL1 = {SIZE{1'b1}};

  logic            clk = 1'b0;
  logic            rst, en, soc, cmp;
  logic [3:0]      swidth;
  logic            sample_n, dac_rst, eoc;
  logic [SIZE-1:0] data;

  sar_adc_ctrl #(.SIZE(SIZE)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .soc_i(soc), .swidth_i(swidth),
    .cmp_i(cmp), .sample_n_o(sample_n), .dac_rst_o(dac_rst), .data_o(data),
    .eoc_o(eoc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Analog front-end model: 0 = real input level, 1 = comparator stuck high, 2 = stuck low.
  int              mode = 0;
  logic [SIZE-1:0] target = '0;
  always_comb begin
    cmp = 1'b0;
    if (mode == 1) cmp = 1'b1;
    else if (mode == 0) cmp = (target >= data);
  end

  typedef struct {
    logic [SIZE-1:0] code;
    int              at;
  } exp_t;

  exp_t eq[$];
  int   swq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t mon_e;
  int   run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (eoc) begin
        if (eq.size() == 0) flag("unexpected_eoc");
        else begin
          mon_e = eq.pop_front();
          check("eoc_data", 32'(data), 32'(mon_e.code));
          check("eoc_cycle", cyc, mon_e.at);
        end
      end
      if (!sample_n) run++;
      else if (run > 0) begin
        if (swq.size() == 0) flag("unexpected_sample_window");
        else check("sample_window", run, swq.pop_front());
        run = 0;
      end
    end
  end

  // Called on a negedge with the DUT idle; returns on the negedge right after capture.
  task automatic start(input logic [SIZE-1:0] v, input int m, input int w, input bit exp_eoc);
    int   weff;
    exp_t e;
    weff   = (w == 0) ? 1 : w;
    target = v;
    mode   = m;
    swidth = 4'(w);
    soc    = 1'b1;
    e.code = (m == 0) ? v : (m == 1) ? ALL1 : '0;
    e.at   = cyc + 1 + weff + SIZE;
    swq.push_back(weff);
    if (exp_eoc) eq.push_back(e);
    @(negedge clk);
    soc    = 1'b0;
    swidth = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((eq.size() != 0 || swq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      flag("timeout_waiting_for_eoc");
      eq.delete();
      swq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; soc = 1'b0; swidth = 4'd4;
    repeat (2) @(negedge clk);
    check("rst_sample_n", 32'(sample_n), 1);
    check("rst_dac_rst", 32'(dac_rst), 1);
    check("rst_data", 32'(data), 0);
    check("rst_eoc", 32'(eoc), 0);
    rst = 1'b0;
    soc = 1'b1;
    repeat (3) @(negedge clk);
    check("en0_sample_n", 32'(sample_n), 1);
    check("en0_dac_rst", 32'(dac_rst), 1);
    soc = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    start(12'hA5C, 0, 4, 1'b1);
    check("conv_dac_rst_low", 32'(dac_rst), 0);
    wait_done();
    check("idle_dac_rst", 32'(dac_rst), 1);
    check("idle_data_held", 32'(data), 32'h00000A5C);

    start(12'h123, 1, 4, 1'b1);
    wait_done();

    start(12'h123, 2, 4, 1'b1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < SIZE; k++) begin
      check("trial_step", 32'(data), 32'(1) << (SIZE - 1 - k));
      @(negedge clk);
    end
    wait_done();

    start(12'h7FF, 0, 0, 1'b1);
    wait_done();
    start(12'h800, 0, 15, 1'b1);
    wait_done();
    start(ALL1, 0, 1, 1'b1);
    wait_done();
    start(12'h000, 0, 2, 1'b1);
    wait_done();

    for (int r = 0; r < 10; r++) begin
      start(SIZE'($urandom), 0, int'($urandom_range(0, 15)), 1'b1);
      wait_done();
    end

    start(12'h5A5, 0, 4, 1'b0);
    repeat (7) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_data", 32'(data), 0);
    check("abort_sample_n", 32'(sample_n), 1);
    check("abort_dac_rst", 32'(dac_rst), 1);
    en = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_eoc_data", 32'(data), 0);
    start(12'h3C3, 0, 4, 1'b1);
    wait_done();

    // soc held high: back-to-back conversions every w+14 edges, mid-conversion soc ignored.
    begin
      int   w;
      int   c0;
      exp_t e;
      w      = 3;
      target = 12'h9E1;
      mode   = 0;
      swidth = 4'(w);
      soc    = 1'b1;
      c0     = cyc;
      for (int k = 0; k < 3; k++) begin
        e.code = 12'h9E1;
        e.at   = c0 + 1 + w + SIZE + k * (w + SIZE + 2);
        eq.push_back(e);
        swq.push_back(w);
      end
      repeat (1 + 2 * (w + SIZE + 2)) @(negedge clk);
      soc = 1'b0;
      wait_done();
    end

    start(12'hBEE, 0, 3, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sample_n", 32'(sample_n), 1);
    check("midrst_dac_rst", 32'(dac_rst), 1);
    check("midrst_data", 32'(data), 0);
    check("midrst_eoc", 32'(eoc), 0);
    rst = 1'b0;
    @(negedge clk);
    start(12'h0F0, 0, 5, 1'b1);
    wait_done();

    repeat (20) @(negedge clk);
    if (eq.size() != 0 || swq.size() != 0) flag("scoreboard_not_drained");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
